slave_mem_ctrl: RTL and testbench
=================================

# slave_mem_ctrl

Slave-side memory controller that sits directly downstream of each slave port in the ADS serial bus system. It owns the slave's local memory array, turns the port's one-cycle write strobe and level-held read request into array accesses, and returns read data with a configurable fixed latency and an `rvalid` flag. The `rvalid` flag is what the slave port waits on before serialising data back to the master.

## Interface
- `ADDR_WIDTH`, 12: memory address width; matches the slave port.
- `DATA_WIDTH`, 8: word width.
- `MEM_DEPTH`, 4096: implemented words, ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 4: cycles from read request sampled to `rvalid` high; legal range 1..15.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `smemwen`  in  1  write strobe: one-cycle pulse per write.
- `smemren`  in  1  read request: level, held high by the port until it finishes sending data.
- `smemaddr`  in  ADDR_WIDTH  word address.
- `smemwdata`  in  DATA_WIDTH  write data.
- `smemrdata`  out  DATA_WIDTH  read data; registered.
- `rvalid`  out  1  `smemrdata` valid for the current read request; registered.

## Operation
- **States:**
  - IDLE: no read in progress.
  - RWAIT: latency countdown.
  - HOLD: data presented.
- **IDLE:**
  - `smemren` sampled high → latch `smemaddr` into `raddr`, load `lcnt` with READ_LATENCY-1, go to RWAIT.
  - If READ_LATENCY=1, go directly to HOLD instead. Capture `mem[raddr]` into `smemrdata` on the next edge and set `rvalid`.
- **RWAIT:**
  - `smemren` low → abort to IDLE; `rvalid` stays 0.
  - `lcnt`==1 and `smemren` high → on the next edge, `smemrdata` ← `mem[raddr]`, `rvalid` ← 1, go to HOLD.
  - Otherwise decrement `lcnt`.
- **HOLD:**
  - `rvalid`=1 and `smemrdata` are held stable while `smemren` stays high.
  - `smemren` low → `rvalid` ← 0 on that edge, go to IDLE.
  - `smemrdata` keeps its last value.
- **Address handling during a read:** changes on `smemaddr` in RWAIT or HOLD are ignored; the address latched in IDLE is used.
- **Writes:**
  - Accepted in every state. `smemwen` high at an edge → `mem[smemaddr]` ← `smemwdata`.
  - No effect on state, `rvalid` or `smemrdata`.
- **Same-edge read capture and write:** the array is read-first. The captured word is the pre-write value; writes at earlier edges are visible.
- **`smemwen` and `smemren` both high in IDLE:** write and read start both occur.
- **Out of range (`smemaddr` ≥ MEM_DEPTH):**
  - Writes are dropped.
  - A read captures all-zeros; `rvalid` still asserts on schedule.
- **Reset:**
  - Any state → IDLE, `rvalid`=0, `smemrdata`=0, `lcnt`=0, `raddr`=0.
  - Memory contents are not reset. An in-flight read is discarded.

## Timing
- Read latency: `smemren` first sampled high at edge E0 → `rvalid` and `smemrdata` change at edge E0+READ_LATENCY.
- `rvalid` falls at the first edge where `smemren` is sampled low.
- Minimum gap between reads: `smemren` must be low for ≥1 sampled edge. Staying high never restarts a read.
- Write: single edge; a read starting at the next edge returns the new value.
- Counter width is 4 bits. `lcnt` never underflows, because its load value is ≥1 whenever RWAIT is entered.
- Both outputs are driven only from flops; there is no combinational path from any input to any output.

## Structure
- Shared package `ads_bus_pkg`:
  - state encodings `SMC_IDLE`=2'b00, `SMC_RWAIT`=2'b01, `SMC_HOLD`=2'b10;
  - `LATENCY_W`=4.
- Sub-module `slave_bram`:
  - simple dual-port, read-first, synchronous array;
  - parameters DATA_WIDTH and MEM_DEPTH;
  - inferable as Cyclone IV M9K.
- The controller holds the FSM, latency counter, address latch, range check and output registers.

## Test plan
- Write 0xA5 to 0x010, then hold `smemren` with address 0x010 (READ_LATENCY=4) → `rvalid` rises exactly 4 edges after the request, `smemrdata`=0xA5, both stable until `smemren` drops, `rvalid`=0 one edge later.
- READ_LATENCY=1: write 0x3C to 0x000, then read → `rvalid`=1 with 0x3C at the first edge after the request.
- Drop `smemren` after 2 cycles of a 4-cycle read → `rvalid` never asserts; a new read of 0x010 then returns 0xA5 after a full 4 cycles.
- Read 0x020 while `smemaddr` toggles to 0x030 in RWAIT; also write 0x77 to 0x020 at edge E0+1 → data 0x77 from 0x020, unaffected by the address change.
- Read address 0xFFF with MEM_DEPTH=2048 → `rvalid` on schedule with 0x00. A write of 0x11 to 0xFFF leaves 0x7FF unchanged.
- Assert `rstn`=0 for one edge in HOLD → `rvalid`=0 and `smemrdata`=0 next edge. Memory still returns 0xA5 at 0x010 afterwards.

Source files
------------

// File: rtl/ads_bus_pkg.sv
// Shared ADS serial-bus definitions: slave memory controller state encodings
// and latency counter width.
package ads_bus_pkg;

  typedef enum logic [1:0] {
    SMC_IDLE  = 2'b00,
    SMC_RWAIT = 2'b01,
    SMC_HOLD  = 2'b10
  } smc_state_t;

  localparam int LATENCY_W = 4;

endpackage

// File: rtl/slave_bram.sv
// Simple dual-port synchronous RAM, read-first on address collision; one write
// port, one registered read port, written to infer a single block RAM.
module slave_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096,
  parameter int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/slave_mem_ctrl.sv
// Slave-side memory controller: write strobe straight into the array, level-held
// read returned after READ_LATENCY edges with rvalid held until the request drops.
module slave_mem_ctrl
  import ads_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  smemwen,
  input  logic                  smemren,
  input  logic [ADDR_WIDTH-1:0] smemaddr,
  input  logic [DATA_WIDTH-1:0] smemwdata,
  output logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  rvalid
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [LATENCY_W-1:0] LCNT_LOAD = LATENCY_W'(READ_LATENCY - 1);

  smc_state_t            state, state_nxt;
  logic [LATENCY_W-1:0]  lcnt, lcnt_nxt;
  logic [ADDR_WIDTH-1:0] raddr, raddr_nxt;
  logic                  rvalid_nxt;
  logic                  capture;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] bram_q;
  logic                  rd_oor_q;
  logic                  fwd_vld_q;
  logic [DATA_WIDTH-1:0] fwd_dat_q;
  logic [DATA_WIDTH-1:0] cap_dat;

  // The array is read one edge before capture; in IDLE this is what lets a
  // single-cycle latency work off the live address.
  assign rd_addr = (state == SMC_IDLE) ? smemaddr : raddr;
  assign wr_ok   = (32'(smemaddr) < 32'(MEM_DEPTH));

  slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_bram (
    .clk   (clk),
    .wen   (smemwen && wr_ok),
    .waddr (smemaddr[IDX_W-1:0]),
    .wdata (smemwdata),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (bram_q)
  );

  // A write landing on the array-read edge must still be seen at capture,
  // since it precedes the capture edge; forward it around the read-first RAM.
  always_ff @(posedge clk) begin
    rd_oor_q  <= (32'(rd_addr) >= 32'(MEM_DEPTH));
    fwd_vld_q <= smemwen && wr_ok && (smemaddr == rd_addr);
    fwd_dat_q <= smemwdata;
  end

  assign cap_dat = rd_oor_q  ? '0 :
                   fwd_vld_q ? fwd_dat_q : bram_q;

  always_comb begin
    state_nxt  = state;
    lcnt_nxt   = lcnt;
    raddr_nxt  = raddr;
    rvalid_nxt = rvalid;
    capture    = 1'b0;
    case (state)
      SMC_IDLE: begin
        if (smemren) begin
          raddr_nxt = smemaddr;
          lcnt_nxt  = LCNT_LOAD;
          state_nxt = (READ_LATENCY == 1) ? SMC_HOLD : SMC_RWAIT;
        end
      end
      SMC_RWAIT: begin
        if (!smemren)                        state_nxt = SMC_IDLE;
        else if (lcnt == LATENCY_W'(1))      state_nxt = SMC_HOLD;
        else                                 lcnt_nxt  = lcnt - 1'b1;
      end
      SMC_HOLD: begin
        if (!smemren) begin
          state_nxt  = SMC_IDLE;
          rvalid_nxt = 1'b0;
        end else if (!rvalid) begin
          capture    = 1'b1;
          rvalid_nxt = 1'b1;
        end
      end
      default: state_nxt = SMC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= SMC_IDLE;
      lcnt      <= '0;
      raddr     <= '0;
      rvalid    <= 1'b0;
      smemrdata <= '0;
    end else begin
      state  <= state_nxt;
      lcnt   <= lcnt_nxt;
      raddr  <= raddr_nxt;
      rvalid <= rvalid_nxt;
      if (capture) smemrdata <= cap_dat;
    end
  end

endmodule

// File: tb/tb_slave_mem_ctrl.sv
// Directed bench: three controllers share one stimulus stream
// (latency 4 / depth 4096, latency 1, depth 2048).
module tb_slave_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        smemwen;
  logic        smemren;
  logic [11:0] smemaddr;
  logic [7:0]  smemwdata;
  logic [7:0]  rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  slave_mem_ctrl #(.READ_LATENCY(4)) dut_a (
    .clk(clk), .rstn(rstn), .smemwen(smemwen), .smemren(smemren),
    .smemaddr(smemaddr), .smemwdata(smemwdata), .smemrdata(rdata_a), .rvalid(rvalid_a));

  slave_mem_ctrl #(.READ_LATENCY(1)) dut_b (
    .clk(clk), .rstn(rstn), .smemwen(smemwen), .smemren(smemren),
    .smemaddr(smemaddr), .smemwdata(smemwdata), .smemrdata(rdata_b), .rvalid(rvalid_b));

  slave_mem_ctrl #(.READ_LATENCY(4), .MEM_DEPTH(2048)) dut_c (
    .clk(clk), .rstn(rstn), .smemwen(smemwen), .smemren(smemren),
    .smemaddr(smemaddr), .smemwdata(smemwdata), .smemrdata(rdata_c), .rvalid(rvalid_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    smemwen   = 1'b1;
    smemaddr  = a;
    smemwdata = d;
    tick();
    smemwen   = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; smemwen = 1'b0; smemren = 1'b0; smemaddr = '0; smemwdata = '0;
    tick(); tick();
    chk("rst_rvalid_a", 16'(rvalid_a), 16'h0);
    chk("rst_rdata_a",  16'(rdata_a),  16'h0);
    chk("rst_rvalid_c", 16'(rvalid_c), 16'h0);
    rstn = 1'b1;
    tick();

    wr(12'h7FF, 8'h55);
    wr(12'hFFF, 8'h11);
    wr(12'h010, 8'hA5);
    wr(12'h020, 8'h12);
    wr(12'h030, 8'h99);
    wr(12'h040, 8'h01);

    // Basic read of 0x010, latency 4 on dut_a and latency 1 on dut_b
    smemren = 1'b1; smemaddr = 12'h010;
    tick();
    chk("rd_e0_rvalid_a", 16'(rvalid_a), 16'h0);
    chk("rd_e0_rvalid_b", 16'(rvalid_b), 16'h0);
    tick();
    chk("rd_e1_rvalid_b", 16'(rvalid_b), 16'h1);
    chk("rd_e1_rdata_b",  16'(rdata_b),  16'hA5);
    chk("rd_e1_rvalid_a", 16'(rvalid_a), 16'h0);
    for (int k = 2; k < 4; k++) begin
      tick();
      chk("rd_wait_rvalid_a", 16'(rvalid_a), 16'h0);
    end
    tick();
    chk("rd_e4_rvalid_a", 16'(rvalid_a), 16'h1);
    chk("rd_e4_rdata_a",  16'(rdata_a),  16'hA5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_hold_rvalid_a", 16'(rvalid_a), 16'h1);
      chk("rd_hold_rdata_a",  16'(rdata_a),  16'hA5);
    end
    smemren = 1'b0;
    tick();
    chk("rd_drop_rvalid_a", 16'(rvalid_a), 16'h0);
    chk("rd_drop_rdata_a",  16'(rdata_a),  16'hA5);
    tick();

    // Latency 1 read of freshly written word
    wr(12'h000, 8'h3C);
    smemren = 1'b1; smemaddr = 12'h000;
    tick();
    chk("l1_e0_rvalid_b", 16'(rvalid_b), 16'h0);
    tick();
    chk("l1_e1_rvalid_b", 16'(rvalid_b), 16'h1);
    chk("l1_e1_rdata_b",  16'(rdata_b),  16'h3C);
    smemren = 1'b0;
    tick();
    chk("l1_drop_rvalid_b", 16'(rvalid_b), 16'h0);
    tick();

    // Abort after two cycles, then a full re-read
    smemren = 1'b1; smemaddr = 12'h010;
    tick(); tick();
    smemren = 1'b0;
    tick();
    chk("abort_rvalid_a", 16'(rvalid_a), 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_idle_rvalid_a", 16'(rvalid_a), 16'h0);
    end
    smemren = 1'b1;
    tick();
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("reread_wait_rvalid_a", 16'(rvalid_a), 16'h0);
    end
    tick();
    chk("reread_rvalid_a", 16'(rvalid_a), 16'h1);
    chk("reread_rdata_a",  16'(rdata_a),  16'hA5);
    smemren = 1'b0;
    tick(); tick();

    // Address toggling in RWAIT is ignored; write at E0+1 is visible
    smemren = 1'b1; smemaddr = 12'h020;
    tick();
    smemwen = 1'b1; smemwdata = 8'h77;
    tick();
    smemwen = 1'b0; smemaddr = 12'h030;
    tick();
    smemaddr = 12'h020;
    tick();
    smemaddr = 12'h030;
    tick();
    chk("addr_rvalid_a", 16'(rvalid_a), 16'h1);
    chk("addr_rdata_a",  16'(rdata_a),  16'h77);
    smemren = 1'b0;
    tick(); tick();

    // Write one edge before capture is seen; write on the capture edge is not
    smemren = 1'b1; smemaddr = 12'h040;
    tick(); tick(); tick();
    smemwen = 1'b1; smemwdata = 8'h02;
    tick();
    smemwdata = 8'h03;
    tick();
    smemwen = 1'b0;
    chk("fwd_rvalid_a", 16'(rvalid_a), 16'h1);
    chk("fwd_rdata_a",  16'(rdata_a),  16'h02);
    smemren = 1'b0;
    tick(); tick();
    smemren = 1'b1;
    tick(); tick();
    chk("post_fwd_rdata_b", 16'(rdata_b), 16'h03);
    smemren = 1'b0;
    tick(); tick();

    // Out-of-range read on the 2048-deep instance
    smemren = 1'b1; smemaddr = 12'hFFF;
    tick();
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("oor_wait_rvalid_c", 16'(rvalid_c), 16'h0);
    end
    tick();
    chk("oor_rvalid_c", 16'(rvalid_c), 16'h1);
    chk("oor_rdata_c",  16'(rdata_c),  16'h00);
    chk("inrange_rdata_a", 16'(rdata_a), 16'h11);
    smemren = 1'b0;
    tick(); tick();
    smemren = 1'b1; smemaddr = 12'h7FF;
    tick(); tick(); tick(); tick(); tick();
    chk("alias_rvalid_c", 16'(rvalid_c), 16'h1);
    chk("alias_rdata_c",  16'(rdata_c),  16'h55);
    smemren = 1'b0;
    tick(); tick();

    // Reset while in HOLD
    smemren = 1'b1; smemaddr = 12'h010;
    tick(); tick(); tick(); tick(); tick();
    chk("prerst_rvalid_a", 16'(rvalid_a), 16'h1);
    rstn = 1'b0;
    tick();
    chk("hold_rst_rvalid_a", 16'(rvalid_a), 16'h0);
    chk("hold_rst_rdata_a",  16'(rdata_a),  16'h00);
    rstn = 1'b1; smemren = 1'b0;
    tick();
    chk("post_rst_rvalid_a", 16'(rvalid_a), 16'h0);
    smemren = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("post_rst_read_rvalid_a", 16'(rvalid_a), 16'h1);
    chk("post_rst_read_rdata_a",  16'(rdata_a),  16'hA5);
    smemren = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
